stepper_ctrl_xy: RTL and testbench
==================================

Name: stepper_ctrl_xy

Overview:
Dual-axis step-pulse generator. It is the consumer (slave side) of the StepperCtrlXY_IF handshake driven by the motion processor. On a trigger it latches X/Y pulse counts and a pulse width, then emits both pulse trains concurrently on the motor step outputs. It reports completion with a single-cycle done and returns to ready. Direction and enable pins are handled by a separate block.

Parameters:
PULSE_NUM_X_BITS, 8, width of the X pulse count.
PULSE_NUM_Y_BITS, 8, width of the Y pulse count.
PULSE_WIDTH_BITS, 8, width of the half-period (high/low phase length) in clocks.

Ports:
clk  input  1  system clock, all logic on its rising edge.
reset  input  1  asynchronous reset, active-low.
intf  StepperCtrlXY_IF.slave  -  command handshake, made up of:
- intf.pulse_num_x: input, PULSE_NUM_X_BITS.
- intf.pulse_num_y: input, PULSE_NUM_Y_BITS.
- intf.pulse_width: input, PULSE_WIDTH_BITS.
- intf.trigger: input, 1.
- intf.done: output, 1.
- intf.rdy: output, 1.
out_x  output  1  X step pulse train.
out_y  output  1  Y step pulse train.

Behaviour:
- Reset values (asynchronous, while reset=0): state=IDLE, rdy=1, done=0, out_x=0, out_y=0, all counters 0.
- States and transitions:
  - IDLE: rdy=1, done=0. If trigger=1 at an edge, latch pulse_num_x, pulse_num_y and W=pulse_width, then go to RUN.
  - RUN: rdy=0. Go to DONE once both axes have finished.
  - DONE: exactly 1 cycle, done=1, rdy=0. Then go to IDLE.
- Trigger is sampled only in IDLE. It is ignored in RUN and DONE, and no command is queued.
- Effective width: W=0 is treated as W=1.
- Each axis has an independent engine with a remaining-pulse counter, a phase-cycle counter and a phase bit.
- Pulse shape: each pulse is W cycles high followed by W cycles low.
- Timing, for trigger accepted at edge T:
  - the first high phase starts in the cycle after T (cycle T+1);
  - an axis with N>0 pulses is high/low for cycles T+1 .. T+2·N·W and is finished after its last low phase.
- Zero count: an axis with N=0 is finished immediately and its output stays 0.
- done timing:
  - done is asserted in cycle T+1+2·max(Nx,Ny)·W;
  - rdy returns to 1 in the next cycle.
  - If Nx=Ny=0, RUN lasts 1 cycle, so done is in T+2 and rdy in T+3.
- A finished axis holds its output at 0 while the other axis continues.
- Counter widths: pulse counters are PULSE_NUM_*_BITS and the phase counter is PULSE_WIDTH_BITS. Maximum values (all ones) must work without wrap-around.
- Output registration: out_x and out_y are registered with no combinational path from the inputs. done and rdy are decoded from state only.
- Reset mid-operation (reset=0 in RUN or DONE): all outputs return to their reset values immediately, and the latched command is discarded.
- Input stability: inputs may change after the trigger edge without affecting the command in progress.

Test Plan:
- Reset then idle: assert reset=0 mid-RUN → out_x=out_y=0, done=0, rdy=1 asynchronously. After release, no pulses are emitted without a trigger.
- Basic unequal move, trigger at T with X=3, Y=1, W=2:
  - out_x is high in cycles T+1–2, T+5–6 and T+9–10;
  - out_y is high in T+1–2 only;
  - done=1 only in T+13, and rdy=1 from T+14.
- Zero counts: X=0, Y=0, W=5 → out_x and out_y stay 0, done in T+2, rdy in T+3. Separately, X=0, Y=2, W=1 → out_x stays 0 and out_y is high in T+1 and T+3.
- Width zero: X=2, Y=2, W=0 → behaves as W=1, with both outputs high in T+1 and T+3 and done in T+5.
- Trigger while busy: during a run of X=4, Y=4, W=3, pulse trigger with X=1 → it is ignored, exactly 4 pulses appear per axis, and there is a single done. Then change the inputs during RUN and confirm the pulse counts are unchanged.
- Max values: X=255, Y=1, W=255 → 255 X pulses and done in T+1+2·255·255 with no counter wrap.

Source files
------------

// File: rtl/stepper_ctrl_xy_if.sv
// StepperCtrlXY_IF: command handshake between the motion processor (master)
// and the dual-axis step-pulse generator (slave).
//
// Handshake: the master may raise trigger at any time; the slave accepts a
// command only on a rising clock edge where rdy=1 and trigger=1, latching
// pulse_num_x, pulse_num_y and pulse_width on that edge. rdy stays low from the
// accepting edge until one cycle after done. done is a single-cycle pulse
// marking completion. A trigger seen while rdy=0 is dropped, not queued.
//
// Signals:
//   pulse_num_x  master->slave  X pulse count
//   pulse_num_y  master->slave  Y pulse count
//   pulse_width  master->slave  high/low phase length in clocks (0 acts as 1)
//   trigger      master->slave  command request
//   done         slave->master  one-cycle completion pulse
//   rdy          slave->master  slave idle and able to accept a command
interface StepperCtrlXY_IF #(
  parameter int PULSE_NUM_X_BITS = 8,
  parameter int PULSE_NUM_Y_BITS = 8,
  parameter int PULSE_WIDTH_BITS = 8
) ();
  logic [PULSE_NUM_X_BITS-1:0] pulse_num_x;
  logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y;
  logic [PULSE_WIDTH_BITS-1:0] pulse_width;
  logic                        trigger;
  logic                        done;
  logic                        rdy;

  modport master (
    output pulse_num_x, pulse_num_y, pulse_width, trigger,
    input  done, rdy
  );

  modport slave (
    input  pulse_num_x, pulse_num_y, pulse_width, trigger,
    output done, rdy
  );
endinterface

// File: rtl/stepper_ctrl_xy.sv
// stepper_ctrl_xy: dual-axis step-pulse generator.
//
// On an accepted trigger the X/Y pulse counts and the phase width are latched
// and both axes emit their pulse trains concurrently. Each pulse is W cycles
// high followed by W cycles low; the first high phase begins in the cycle
// right after the accepting edge. When both axes have finished, done pulses
// for one cycle and the block returns to ready.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   intf       StepperCtrlXY_IF.slave command handshake
//   out_x      registered X step output
//   out_y      registered Y step output
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
module stepper_ctrl_xy #(
  parameter int PULSE_NUM_X_BITS = 8,
  parameter int PULSE_NUM_Y_BITS = 8,
  parameter int PULSE_WIDTH_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  StepperCtrlXY_IF.slave       intf,
  output logic                 out_x,
  output logic                 out_y,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PULSE_NUM_X_BITS-1:0] ONE_X = PULSE_NUM_X_BITS'(1);
  localparam logic [PULSE_NUM_Y_BITS-1:0] ONE_Y = PULSE_NUM_Y_BITS'(1);
  localparam logic [PULSE_WIDTH_BITS-1:0] ONE_W = PULSE_WIDTH_BITS'(1);

  state_t                      state_q, state_d;
  logic [PULSE_WIDTH_BITS-1:0] w_q, w_d;

  // Per-axis engine: remaining pulses (including the one in progress),
  // cycles spent in the current phase, phase bit (= step output), and an
  // active flag that drops after the last low phase.
  logic [PULSE_NUM_X_BITS-1:0] remain_x_q, remain_x_d;
  logic [PULSE_WIDTH_BITS-1:0] cnt_x_q, cnt_x_d;
  logic                        out_x_q, out_x_d;
  logic                        act_x_q, act_x_d;

  logic [PULSE_NUM_Y_BITS-1:0] remain_y_q, remain_y_d;
  logic [PULSE_WIDTH_BITS-1:0] cnt_y_q, cnt_y_d;
  logic                        out_y_q, out_y_d;
  logic                        act_y_q, act_y_d;

  logic                        phase_end_x, phase_end_y;

  // The phase counter only ever reaches w_q-1, so all-ones widths never wrap.
  assign phase_end_x = (cnt_x_q == (w_q - ONE_W));
  assign phase_end_y = (cnt_y_q == (w_q - ONE_W));

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    remain_x_d = remain_x_q;
    cnt_x_d    = cnt_x_q;
    out_x_d    = out_x_q;
    act_x_d    = act_x_q;
    remain_y_d = remain_y_q;
    cnt_y_d    = cnt_y_q;
    out_y_d    = out_y_q;
    act_y_d    = act_y_q;

    case (state_q)
      ST_IDLE: begin
        if (intf.trigger) begin
          w_d        = (intf.pulse_width == '0) ? ONE_W : intf.pulse_width;
          remain_x_d = intf.pulse_num_x;
          remain_y_d = intf.pulse_num_y;
          cnt_x_d    = '0;
          cnt_y_d    = '0;
          // Output rises on the accepting edge so the first high phase
          // occupies the very next cycle; a zero-count axis never starts.
          act_x_d    = (intf.pulse_num_x != '0);
          act_y_d    = (intf.pulse_num_y != '0);
          out_x_d    = (intf.pulse_num_x != '0);
          out_y_d    = (intf.pulse_num_y != '0);
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        if (act_x_q) begin
          if (phase_end_x) begin
            cnt_x_d = '0;
            if (out_x_q) begin
              out_x_d = 1'b0;
            end else if (remain_x_q == ONE_X) begin
              remain_x_d = '0;
              act_x_d    = 1'b0;
            end else begin
              remain_x_d = remain_x_q - ONE_X;
              out_x_d    = 1'b1;
            end
          end else begin
            cnt_x_d = cnt_x_q + ONE_W;
          end
        end

        if (act_y_q) begin
          if (phase_end_y) begin
            cnt_y_d = '0;
            if (out_y_q) begin
              out_y_d = 1'b0;
            end else if (remain_y_q == ONE_Y) begin
              remain_y_d = '0;
              act_y_d    = 1'b0;
            end else begin
              remain_y_d = remain_y_q - ONE_Y;
              out_y_d    = 1'b1;
            end
          end else begin
            cnt_y_d = cnt_y_q + ONE_W;
          end
        end

        // Leave RUN on the edge that ends the last low phase of the longer
        // axis, so done lands in the following cycle.
        if (!act_x_d && !act_y_d) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      remain_x_q <= '0;
      cnt_x_q    <= '0;
      out_x_q    <= 1'b0;
      act_x_q    <= 1'b0;
      remain_y_q <= '0;
      cnt_y_q    <= '0;
      out_y_q    <= 1'b0;
      act_y_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      remain_x_q <= remain_x_d;
      cnt_x_q    <= cnt_x_d;
      out_x_q    <= out_x_d;
      act_x_q    <= act_x_d;
      remain_y_q <= remain_y_d;
      cnt_y_q    <= cnt_y_d;
      out_y_q    <= out_y_d;
      act_y_q    <= act_y_d;
    end
  end

  assign intf.rdy  = (state_q == ST_IDLE);
  assign intf.done = (state_q == ST_DONE);
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stepper_ctrl_xy.sv
// Testbench for stepper_ctrl_xy. The phase width is narrowed to 6 bits so the
// all-ones corner (255 X pulses at W=63) stays a short simulation while still
// exercising every counter at its maximum value.
module tb_stepper_ctrl_xy;

  localparam int XB = 8;
  localparam int YB = 8;
  localparam int WB = 6;
  localparam int BUDGET = 40000;

  logic       clk;
  logic       reset;
  logic       out_x;
  logic       out_y;
  logic [1:0] dbg_state;

  StepperCtrlXY_IF #(
    .PULSE_NUM_X_BITS(XB),
    .PULSE_NUM_Y_BITS(YB),
    .PULSE_WIDTH_BITS(WB)
  ) intf ();

  stepper_ctrl_xy #(
    .PULSE_NUM_X_BITS(XB),
    .PULSE_NUM_Y_BITS(YB),
    .PULSE_WIDTH_BITS(WB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .intf      (intf.slave),
    .out_x     (out_x),
    .out_y     (out_y),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Vector: command, expected done cycle (relative to accepting edge T),
  // pulse counts, and the per-cycle output pattern for cycles T+1..T+16
  // (bit k-1 = cycle T+k).
  typedef struct {
    logic [XB-1:0] nx;
    logic [YB-1:0] ny;
    logic [WB-1:0] w;
    logic          busy;
    int            exp_done;
    int            exp_px;
    int            exp_py;
    logic [15:0]   exp_mx;
    logic [15:0]   exp_my;
  } vec_t;

  function automatic vec_t mk(input logic [XB-1:0] nx, input logic [YB-1:0] ny,
                              input logic [WB-1:0] w, input logic busy,
                              input int d, input int px, input int py,
                              input logic [15:0] mx, input logic [15:0] my);
    vec_t v;
    v.nx = nx; v.ny = ny; v.w = w; v.busy = busy;
    v.exp_done = d; v.exp_px = px; v.exp_py = py;
    v.exp_mx = mx; v.exp_my = my;
    return v;
  endfunction

  vec_t vecs[8];

  // driver: issue one command, watch the run, compare against the vector
  task automatic run_vec(input int idx, input vec_t v);
    int          done_k;
    int          done_n;
    int          px;
    int          py;
    logic        prev_x;
    logic        prev_y;
    logic [15:0] mx;
    logic [15:0] my;
    string       p;
    p = $sformatf("v%0d", idx);
    done_k = 0; done_n = 0; px = 0; py = 0;
    prev_x = 1'b0; prev_y = 1'b0; mx = '0; my = '0;

    @(negedge clk);
    check({p, "_rdy_before"}, 32'(intf.rdy), 32'd1);
    intf.pulse_num_x = v.nx;
    intf.pulse_num_y = v.ny;
    intf.pulse_width = v.w;
    intf.trigger     = 1'b1;
    @(posedge clk);
    #1;
    intf.trigger     = 1'b0;
    // command in progress must not follow the inputs
    intf.pulse_num_x = XB'($urandom_range(0, 255));
    intf.pulse_num_y = YB'($urandom_range(0, 255));
    intf.pulse_width = WB'($urandom_range(0, 63));

    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        mx[k-1] = out_x;
        my[k-1] = out_y;
      end
      if (out_x && !prev_x) px++;
      if (out_y && !prev_y) py++;
      prev_x = out_x;
      prev_y = out_y;
      if (k == 1) check({p, "_rdy_run"}, 32'(intf.rdy), 32'd0);
      if (intf.done) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          check({p, "_rdy_at_done"}, 32'(intf.rdy), 32'd0);
        end
      end
      if (done_k != 0 && k == done_k + 1)
        check({p, "_rdy_after"}, 32'(intf.rdy), 32'd1);
      if (v.busy) begin
        if (k == 5) begin
          intf.pulse_num_x = XB'(1);
          intf.trigger     = 1'b1;
        end
        if (k == 6) intf.trigger = 1'b0;
        if (k == 10) begin
          intf.pulse_num_x = XB'(7);
          intf.pulse_num_y = YB'(9);
          intf.pulse_width = WB'(1);
        end
      end
      if (done_k != 0 && k == done_k + 8) break;
    end

    check({p, "_done_seen"}, 32'(done_k != 0), 32'd1);
    check({p, "_done_cycle"}, 32'(done_k), 32'(v.exp_done));
    check({p, "_done_count"}, 32'(done_n), 32'd1);
    check({p, "_pulses_x"}, 32'(px), 32'(v.exp_px));
    check({p, "_pulses_y"}, 32'(py), 32'(v.exp_py));
    check({p, "_shape_x"}, 32'(mx), 32'(v.exp_mx));
    check({p, "_shape_y"}, 32'(my), 32'(v.exp_my));
  endtask

  initial begin
    int hi_cnt;
    intf.pulse_num_x = '0;
    intf.pulse_num_y = '0;
    intf.pulse_width = '0;
    intf.trigger     = 1'b0;
    reset            = 1'b0;

    //          nx     ny    w     busy done   px   py  shape_x   shape_y
    vecs[0] = mk(8'd3,   8'd1, 6'd2,  1'b0, 13,    3,   1,  16'h0333, 16'h0003);
    vecs[1] = mk(8'd0,   8'd0, 6'd5,  1'b0, 2,     0,   0,  16'h0000, 16'h0000);
    vecs[2] = mk(8'd0,   8'd2, 6'd1,  1'b0, 5,     0,   2,  16'h0000, 16'h0005);
    vecs[3] = mk(8'd2,   8'd2, 6'd0,  1'b0, 5,     2,   2,  16'h0005, 16'h0005);
    vecs[4] = mk(8'd1,   8'd3, 6'd1,  1'b0, 7,     1,   3,  16'h0001, 16'h0015);
    vecs[5] = mk(8'd4,   8'd4, 6'd3,  1'b1, 25,    4,   4,  16'h71C7, 16'h71C7);
    vecs[6] = mk(8'd2,   8'd5, 6'd2,  1'b0, 21,    2,   5,  16'h0033, 16'h3333);
    vecs[7] = mk(8'd255, 8'd1, 6'd63, 1'b0, 32131, 255, 1,  16'hFFFF, 16'hFFFF);

    // reset values while reset is held
    #1;
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_done", 32'(intf.done), 32'd0);
    check("rst_rdy", 32'(intf.rdy), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // reset in the middle of a run: outputs drop without a clock edge
    @(negedge clk);
    intf.pulse_num_x = 8'd3;
    intf.pulse_num_y = 8'd3;
    intf.pulse_width = 6'd4;
    intf.trigger     = 1'b1;
    @(posedge clk);
    #1;
    intf.trigger = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_running_x", 32'(out_x), 32'd1);
    check("midrst_rdy_low", 32'(intf.rdy), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_x", 32'(out_x), 32'd0);
    check("midrst_out_y", 32'(out_y), 32'd0);
    check("midrst_done", 32'(intf.done), 32'd0);
    check("midrst_rdy", 32'(intf.rdy), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    // discarded command must not resume, and nothing runs without a trigger
    hi_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_x || out_y || intf.done || !intf.rdy) hi_cnt++;
    end
    check("post_rst_quiet", 32'(hi_cnt), 32'd0);

    // a fresh command after the reset still runs normally
    run_vec(8, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
